// File: rtl/layer_param_loader.sv
// Deserialises one x/W/b stream frame into the packed buses consumed by Layer.
// Optional macro LOADER_WEIGHT_HOLD_EN: w_hold frames reload only the input vector.
module layer_param_loader #(
    parameter int IN_N       = 4,
    parameter int OUT_N      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_last,
    input  logic                              w_hold,
    output logic [IN_N*DATA_WIDTH-1:0]        in_vec,
    output logic [OUT_N*IN_N*DATA_WIDTH-1:0]  weights,
    output logic [OUT_N*DATA_WIDTH-1:0]       biases,
    output logic                              params_valid,
    input  logic                              params_ack,
    output logic                              frame_err
);

    localparam int W_N   = OUT_N * IN_N;
    localparam int CNT_W = $clog2(W_N + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_W,
        LOAD_B,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             hold_now;
    logic             is_final;
    logic             bad_last;

    assign accept = s_valid && s_ready;

`ifdef LOADER_WEIGHT_HOLD_EN
    logic hold_frame;

    // w_hold only matters on the first beat; afterwards the latched copy rules.
    assign hold_now = (state == IDLE) ? w_hold : hold_frame;
`else
    logic unused_w_hold;

    assign unused_w_hold = w_hold;
    assign hold_now      = 1'b0;
`endif

    always_comb begin
        is_final = 1'b0;
        case (state)
            IDLE:    is_final = hold_now && (IN_N == 1);
            LOAD_X:  is_final = hold_now && (count == CNT_W'(IN_N - 1));
            LOAD_B:  is_final = (count == CNT_W'(OUT_N - 1));
            default: is_final = 1'b0;
        endcase
    end

    // s_last must appear on exactly the final beat of the frame.
    assign bad_last = (s_last != is_final);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            s_ready      <= 1'b0;
            in_vec       <= '0;
            weights      <= '0;
            biases       <= '0;
            params_valid <= 1'b0;
            frame_err    <= 1'b0;
`ifdef LOADER_WEIGHT_HOLD_EN
            hold_frame   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        in_vec[0 +: DATA_WIDTH] <= s_data;
`ifdef LOADER_WEIGHT_HOLD_EN
                        hold_frame <= w_hold;
`endif
                        if (bad_last) begin
                            frame_err <= 1'b1;
                            count     <= '0;
                        end else if (IN_N == 1) begin
                            count <= '0;
                            if (hold_now) begin
                                state        <= DONE;
                                s_ready      <= 1'b0;
                                params_valid <= 1'b1;
                            end else begin
                                state <= LOAD_W;
                            end
                        end else begin
                            state <= LOAD_X;
                            count <= CNT_W'(1);
                        end
                    end
                end

                LOAD_X: begin
                    if (accept) begin
                        in_vec[count*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                        if (bad_last) begin
                            state     <= IDLE;
                            count     <= '0;
                            frame_err <= 1'b1;
                        end else if (count == CNT_W'(IN_N - 1)) begin
                            count <= '0;
                            if (hold_now) begin
                                state        <= DONE;
                                s_ready      <= 1'b0;
                                params_valid <= 1'b1;
                            end else begin
                                state <= LOAD_W;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                // Neuron-major order: beat k lands in slot k = neuron*IN_N + input.
                LOAD_W: begin
                    if (accept) begin
                        weights[count*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                        if (bad_last) begin
                            state     <= IDLE;
                            count     <= '0;
                            frame_err <= 1'b1;
                        end else if (count == CNT_W'(W_N - 1)) begin
                            state <= LOAD_B;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                LOAD_B: begin
                    if (accept) begin
                        biases[count*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                        if (bad_last) begin
                            state     <= IDLE;
                            count     <= '0;
                            frame_err <= 1'b1;
                        end else if (count == CNT_W'(OUT_N - 1)) begin
                            state        <= DONE;
                            count        <= '0;
                            s_ready      <= 1'b0;
                            params_valid <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (params_ack) begin
                        state        <= IDLE;
                        params_valid <= 1'b0;
                        s_ready      <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed self-checking bench for layer_param_loader (default 4x8x8 configuration).
// Define LOADER_WEIGHT_HOLD_EN for both files to exercise the input-only frame.
module tb_layer_param_loader;

    localparam int IN_N  = 4;
    localparam int OUT_N = 8;
    localparam int DW    = 8;
    localparam int NBEAT = IN_N + OUT_N*IN_N + OUT_N;

    logic                       clk;
    logic                       rst_n;
    logic                       s_valid;
    logic                       s_ready;
    logic [DW-1:0]              s_data;
    logic                       s_last;
    logic                       w_hold;
    logic [IN_N*DW-1:0]         in_vec;
    logic [OUT_N*IN_N*DW-1:0]   weights;
    logic [OUT_N*DW-1:0]        biases;
    logic                       params_valid;
    logic                       params_ack;
    logic                       frame_err;

    logic [IN_N*DW-1:0]         exp_in_vec;
    logic [OUT_N*IN_N*DW-1:0]   exp_weights;
    logic [OUT_N*DW-1:0]        exp_biases;

    int num_checks = 0;
    int num_fail   = 0;

    layer_param_loader #(.IN_N(IN_N), .OUT_N(OUT_N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .w_hold(w_hold),
        .in_vec(in_vec), .weights(weights), .biases(biases),
        .params_valid(params_valid), .params_ack(params_ack),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beat value for frame offset 'base': x[j]=base+j+1, W(i,j)=base+i+j, b[i]=base+i.
    function automatic logic [DW-1:0] beatData(input int base, input int k);
        int kk;
        if (k < IN_N) return DW'(base + k + 1);
        if (k < IN_N + OUT_N*IN_N) begin
            kk = k - IN_N;
            return DW'(base + kk/IN_N + kk%IN_N);
        end
        return DW'(base + k - IN_N - OUT_N*IN_N);
    endfunction

    task automatic buildModel(input int base);
        for (int j = 0; j < IN_N; j++) exp_in_vec[j*DW +: DW] = DW'(base + j + 1);
        for (int i = 0; i < OUT_N; i++) begin
            for (int j = 0; j < IN_N; j++) exp_weights[(i*IN_N+j)*DW +: DW] = DW'(base + i + j);
            exp_biases[i*DW +: DW] = DW'(base + i);
        end
    endtask

    // Drives one beat and returns 1 time unit after the edge that accepted it.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic last, input logic hold);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        w_hold  = hold;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) checkOutput("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        w_hold  = 1'b0;
    endtask

    task automatic sendFrame(input int base, input int stop_at, input bit final_last);
        for (int k = 0; k < NBEAT; k++) begin
            applyStimulus(beatData(base, k), (k == stop_at) || (k == NBEAT-1 && final_last), 1'b0);
            if (k == stop_at) break;
        end
    endtask

    task automatic checkBuses(input string tag);
        checkOutput({tag, "_in_vec"},  in_vec,  exp_in_vec);
        checkOutput({tag, "_weights"}, weights, exp_weights);
        checkOutput({tag, "_biases"},  biases,  exp_biases);
    endtask

    task automatic ackFrame();
        params_ack = 1'b1;
        @(posedge clk);
        #1;
        params_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        w_hold = 1'b0; params_ack = 1'b0;
        #7;
        checkOutput("rst_ready",  s_ready, 0);
        checkOutput("rst_valid",  params_valid, 0);
        checkOutput("rst_err",    frame_err, 0);
        checkOutput("rst_buses",  {in_vec, weights, biases}, 0);
        #16 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_ready", s_ready, 1);

        // Full frame with reference values.
        sendFrame(0, -1, 1'b1);
        buildModel(0);
        checkOutput("f1_valid",  params_valid, 1);
        checkOutput("f1_ready",  s_ready, 0);
        checkOutput("f1_x01",    in_vec[15:0], 16'h0201);
        checkOutput("f1_w23",    weights[(2*IN_N+3)*DW +: DW], 5);
        checkOutput("f1_b7",     biases[7*DW +: DW], 7);
        checkBuses("f1");

        // DONE with a pending word and a delayed ack.
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checkOutput("done_ready_low", s_ready, 0);
            checkOutput("done_valid_hi",  params_valid, 1);
        end
        params_ack = 1'b1;
        @(posedge clk); #1;
        params_ack = 1'b0; s_valid = 1'b0;
        checkOutput("ack_valid_low", params_valid, 0);
        checkOutput("ack_ready_hi",  s_ready, 1);
        checkBuses("ack_unchanged");

        // Early s_last inside the weight phase (beat 10).
        sendFrame(20, 9, 1'b0);
        checkOutput("early_err_pulse", frame_err, 1);
        checkOutput("early_no_valid",  params_valid, 0);
        @(posedge clk); #1;
        checkOutput("early_err_clear", frame_err, 0);
        checkOutput("early_idle_ready", s_ready, 1);
        sendFrame(10, -1, 1'b1);
        buildModel(10);
        checkOutput("f2_valid", params_valid, 1);
        checkBuses("f2");
        ackFrame();

        // Final bias beat missing s_last.
        sendFrame(30, -1, 1'b0);
        checkOutput("nolast_err_pulse", frame_err, 1);
        checkOutput("nolast_no_valid",  params_valid, 0);
        checkOutput("nolast_ready",     s_ready, 1);
        @(posedge clk); #1;
        checkOutput("nolast_err_clear", frame_err, 0);
        checkOutput("nolast_still_no_valid", params_valid, 0);

        // Asynchronous reset after beat 20.
        for (int k = 0; k < 20; k++) applyStimulus(beatData(40, k), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_buses", {in_vec, weights, biases}, 0);
        checkOutput("midrst_ready", s_ready, 0);
        checkOutput("midrst_flags", {params_valid, frame_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sendFrame(50, -1, 1'b1);
        buildModel(50);
        checkOutput("f3_valid", params_valid, 1);
        checkBuses("f3");
        ackFrame();

`ifdef LOADER_WEIGHT_HOLD_EN
        applyStimulus(8'hFF, 1'b0, 1'b1);
        applyStimulus(8'hFE, 1'b0, 1'b0);
        applyStimulus(8'hFD, 1'b0, 1'b0);
        applyStimulus(8'hFC, 1'b1, 1'b0);
        checkOutput("hold_valid", params_valid, 1);
        checkOutput("hold_err",   frame_err, 0);
        checkOutput("hold_in_vec", in_vec, 32'hFCFDFEFF);
        checkOutput("hold_weights", weights, exp_weights);
        checkOutput("hold_biases",  biases,  exp_biases);
        ackFrame();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/layer_param_loader.md
Name: layer_param_loader

Overview:
- Front-end feeder for the Layer datapath.
- Accepts one serial stream of signed DATA_WIDTH words over a valid/ready handshake. Each frame holds the input vector, then the weights, then the biases.
- Deserialises the frame into the packed in_vec/weights/biases buses that Layer consumes.
- Presents the buses with a params_valid/params_ack handshake, so Layer's packed interface can be driven from a narrow host or DMA port.

Parameters:
- IN_N, 4, input vector length (Layer IN_N).
- OUT_N, 8, output neuron count (Layer OUT_N).
- DATA_WIDTH, 8, signed element width (matches `DATA_WIDTH).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  DATA_WIDTH  signed stream word.
- s_last  in  1  marks final word of frame.
- w_hold  in  1  sampled on first word of frame; only used with LOADER_WEIGHT_HOLD_EN.
- in_vec  out  IN_N*DATA_WIDTH  packed inputs, element j at [j*DATA_WIDTH +: DATA_WIDTH].
- weights  out  OUT_N*IN_N*DATA_WIDTH  packed weights, W[j][i] at [(i*IN_N+j)*DATA_WIDTH +: DATA_WIDTH].
- biases  out  OUT_N*DATA_WIDTH  packed biases, element i at [i*DATA_WIDTH +: DATA_WIDTH].
- params_valid  out  1  packed buses hold a complete frame.
- params_ack  in  1  consumer has taken the buses.
- frame_err  out  1  one-cycle pulse on malformed frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - s_ready=0 during reset, 1 after release.
  - in_vec, weights, biases all zero.
  - params_valid=0, frame_err=0.
  - Word counter zero.
- A beat is accepted when s_valid && s_ready at a rising edge.
- States and transitions:
  - IDLE: s_ready=1. First accepted beat is x[0] → LOAD_X with counter=1.
  - LOAD_X: beats fill in_vec j=0..IN_N-1. After x[IN_N-1] → LOAD_W.
  - LOAD_W: beats k=0..OUT_N*IN_N-1 are neuron-major. Beat k writes weight slot k, i.e. neuron i=k/IN_N, input j=k%IN_N. After the last weight → LOAD_B.
  - LOAD_B: beats fill biases i=0..OUT_N-1. The final bias beat must carry s_last=1; then → DONE.
- Full frame is IN_N + OUT_N*IN_N + OUT_N beats (default 44).
- DONE:
  - s_ready=0.
  - params_valid=1, asserted the cycle after the final beat is accepted.
  - Packed buses are stable while params_valid=1.
  - params_ack=1 in DONE → IDLE next edge; params_valid drops the same edge, s_ready rises.
- params_ack outside DONE is ignored.
- Each element register is written only on its own accepted beat. No sign-extension or arithmetic; words are stored verbatim.
- Error rules:
  - s_last=1 on any accepted beat that is not the final frame beat → frame_err pulse, return to IDLE, counter cleared, params_valid stays 0.
  - s_last=0 on the final bias beat → same error handling.
  - Partially written registers keep their values; the next good frame overwrites them fully.
- Single-word case: s_last on the first beat while IDLE is an error.
- s_valid held high with s_ready=0 (DONE) is legal; the word is not consumed.
- Back-to-back frames: minimum one dead cycle (DONE→IDLE) between frames, plus any ack delay.
- Counter width is $clog2(OUT_N*IN_N+1). It resets to 0 on each phase change and on error.
- Async reset mid-frame discards the frame immediately and clears all outputs.

Optional Feature:
- Macro: LOADER_WEIGHT_HOLD_EN.
- Defined:
  - If w_hold=1 on the first accepted beat of a frame, the frame is IN_N words only.
  - LOAD_W and LOAD_B are skipped. The beat x[IN_N-1] must carry s_last, then → DONE.
  - Weights and biases keep their previous values.
  - w_hold=0 gives a normal full frame.
- Not defined: w_hold is ignored; every frame is a full frame and the hold-path logic is not synthesised.

Test Plan:
- Reset then full frame of 44 beats, x={1,2,3,4}, W[j][i]=i+j, biases=i, s_last on beat 44 → params_valid=1 one cycle after beat 44.
  - in_vec[15:0] reads 16'h0201.
  - Weight slot (i=2, j=3) = 5.
  - biases[7*8+:8] = 7.
- DONE with s_valid held and params_ack delayed 5 cycles → s_ready=0 throughout and no words consumed; params_valid falls and s_ready rises on the edge after ack.
- s_last asserted on beat 10 (inside LOAD_W) → frame_err high for exactly 1 cycle, params_valid=0. A following clean frame loads correctly.
- Final bias beat sent with s_last=0 → frame_err pulse, state IDLE, no params_valid.
- rst_n pulsed low at beat 20 → all outputs zero immediately. After release, a full frame completes normally.
- With LOADER_WEIGHT_HOLD_EN: full frame, ack, then a 4-beat frame with w_hold=1 and x={-1,-2,-3,-4} → params_valid after beat 4, in_vec=32'hFCFDFEFF, weights/biases unchanged from the prior frame.
